// File: rtl/turf_trig_pkg.sv
// Shared encodings for the TURF trigger scheduler: FSM states, trigger
// source bit positions and buf_status_o field offsets.
package turf_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_ANNOUNCE = 2'd2,
        ST_DEAD     = 2'd3
    } sched_state_e;

    localparam int NSRC     = 4;
    localparam int SRC_RF   = 0;
    localparam int SRC_SOFT = 1;
    localparam int SRC_PPS1 = 2;
    localparam int SRC_PPS2 = 3;

    localparam int STAT_HOLD_LSB  = 0;
    localparam int STAT_OCC_LSB   = 4;
    localparam int STAT_WR_LSB    = 8;
    localparam int STAT_RD_LSB    = 10;
    localparam int STAT_BUSY_BIT  = 12;
    localparam int STAT_STATE_LSB = 13;
    localparam int STAT_FULL_BIT  = 15;
    localparam int STAT_LOST_LSB  = 16;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [2:0] src_count(input logic [NSRC-1:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/turf_buf_ring.sv
// Ring of SURF buffers: allocates at wr_ptr, releases oldest at rd_ptr and
// keeps the per-buffer hold mask and occupancy in step with both pointers.
module turf_buf_ring
    import turf_trig_pkg::*;
#(
    parameter int NBUF = 4,
    localparam int PW = ptr_width(NBUF)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            alloc,
    input  logic            rel,
    output logic [NBUF-1:0] hold,
    output logic [PW-1:0]   wr_ptr,
    output logic [PW-1:0]   rd_ptr,
    output logic [2:0]      occupancy,
    output logic            full,
    output logic            empty
);

    logic            alloc_ok;
    logic            rel_ok;
    logic [NBUF-1:0] hold_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == NBUF - 1) ? '0 : p + 1'b1;
    endfunction

    assign full     = (occupancy == 3'(NBUF));
    assign empty    = (occupancy == 3'd0);
    assign alloc_ok = alloc && !full;
    assign rel_ok   = rel && !empty;

    // Alloc and release never target the same slot: alloc needs a free
    // slot, release needs a held one, so wr_ptr != rd_ptr when both fire.
    always_comb begin
        hold_nxt = hold;
        if (alloc_ok) hold_nxt[wr_ptr] = 1'b1;
        if (rel_ok)   hold_nxt[rd_ptr] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clr) begin
            hold      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            hold <= hold_nxt;
            if (alloc_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rel_ok)   rd_ptr <= ptr_inc(rd_ptr);
            case ({alloc_ok, rel_ok})
                2'b10:   occupancy <= occupancy + 3'd1;
                2'b01:   occupancy <= occupancy - 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/turf_buffer_scheduler.sv
// TURF trigger scheduler: latches trigger sources, grants one SURF buffer per
// event, sequences HOLD settle / announce / deadtime and tracks event IDs.
module turf_buffer_scheduler
    import turf_trig_pkg::*;
#(
    parameter int NBUF       = 4,
    parameter int HOLD_DELAY = 8,
    parameter int DEADTIME   = 16
)(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            rf_trig_i,
    input  logic            soft_trig_i,
    input  logic            pps1_trig_i,
    input  logic            pps2_trig_i,
    input  logic            disable_i,
    input  logic            clr_evt_i,
    input  logic            clr_all_i,
    input  logic [11:0]     epoch_i,
    input  logic            evid_reset_i,
    output logic [NBUF-1:0] hold_o,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [1:0]      evt_buf_o,
    output logic [3:0]      evt_type_o,
    output logic [31:0]     evt_id_o,
    output logic [31:0]     next_id_o,
    output logic [31:0]     buf_status_o
);

    localparam int PW = ptr_width(NBUF);

    sched_state_e    state, state_nxt;
    logic [7:0]      dly_cnt, dly_nxt;
    logic [NSRC-1:0] trig_vec, new_trig, pending, dup_trig;
    logic [15:0]     lost_cnt;
    logic [16:0]     lost_sum;
    logic [19:0]     id_ctr, id_use;
    logic            grant, rel;
    logic [NBUF-1:0] hold;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [2:0]      occupancy;
    logic            full, empty;

    always_comb begin
        trig_vec           = '0;
        trig_vec[SRC_RF]   = rf_trig_i;
        trig_vec[SRC_SOFT] = soft_trig_i;
        trig_vec[SRC_PPS1] = pps1_trig_i;
        trig_vec[SRC_PPS2] = pps2_trig_i;
    end

    // A pulse landing on an already-pending source is lost, except in the
    // grant cycle where it becomes the first pending bit of the next event.
    assign new_trig = disable_i ? '0 : trig_vec;
    assign grant    = (state == ST_IDLE) && (|pending) && !full && !clr_all_i;
    assign rel      = clr_evt_i && !empty;
    assign dup_trig = new_trig & pending & {NSRC{!grant}};
    assign lost_sum = {1'b0, lost_cnt} + 17'(src_count(dup_trig));
    assign id_use   = evid_reset_i ? '0 : id_ctr;

    turf_buf_ring #(.NBUF(NBUF)) u_ring (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .clr       (clr_all_i),
        .alloc     (grant),
        .rel       (rel),
        .hold      (hold),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        if (clr_all_i) begin
            state_nxt = ST_IDLE;
            dly_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state_nxt = ST_HOLD;
                        dly_nxt   = 8'(HOLD_DELAY - 1);
                    end
                end
                ST_HOLD: begin
                    if (dly_cnt == '0) state_nxt = ST_ANNOUNCE;
                    else               dly_nxt   = dly_cnt - 8'd1;
                end
                ST_ANNOUNCE: begin
                    if (evt_ready_i) begin
                        state_nxt = ST_DEAD;
                        dly_nxt   = (DEADTIME == 0) ? 8'd0 : 8'(DEADTIME - 1);
                    end
                end
                ST_DEAD: begin
                    if (dly_cnt == '0) state_nxt = ST_IDLE;
                    else               dly_nxt   = dly_cnt - 8'd1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            dly_cnt <= '0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending  <= '0;
            lost_cnt <= '0;
        end else if (clr_all_i) begin
            pending  <= '0;
            lost_cnt <= '0;
        end else begin
            pending <= (grant ? '0 : pending) | new_trig;
            if (|dup_trig) lost_cnt <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
        end
    end

    // The ID counter survives clr_all; only reset and evid_reset_i touch it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            evt_type_o <= '0;
            evt_buf_o  <= '0;
            evt_id_o   <= '0;
            id_ctr     <= '0;
        end else if (grant) begin
            evt_type_o <= pending;
            evt_buf_o  <= 2'(wr_ptr);
            evt_id_o   <= {epoch_i, id_use};
            id_ctr     <= id_use + 20'd1;
        end else if (evid_reset_i) begin
            id_ctr <= '0;
        end
    end

    // Announce handshake: evt_valid_o rises in ANNOUNCE and stays high with
    // fields frozen until a rising edge samples evt_ready_i high; the transfer
    // happens on that edge. evt_valid_o never depends on evt_ready_i.
    assign evt_valid_o = (state == ST_ANNOUNCE);
    assign hold_o      = hold;
    assign next_id_o   = {epoch_i, id_ctr};

    always_comb begin
        buf_status_o                               = '0;
        buf_status_o[STAT_HOLD_LSB +: 4]           = 4'(hold);
        buf_status_o[STAT_OCC_LSB +: 3]            = occupancy;
        buf_status_o[STAT_WR_LSB +: 2]             = 2'(wr_ptr);
        buf_status_o[STAT_RD_LSB +: 2]             = 2'(rd_ptr);
        buf_status_o[STAT_BUSY_BIT]                = (state != ST_IDLE);
        buf_status_o[STAT_STATE_LSB +: 2]          = state;
        buf_status_o[STAT_FULL_BIT]                = full;
        buf_status_o[STAT_LOST_LSB +: 16]          = lost_cnt;
    end

endmodule

// File: tb/tb_turf_buffer_scheduler.sv
// Directed bench for turf_buffer_scheduler: table of single-event vectors
// plus hand-written sequences for full ring, stall, clr_all, IDs and reset.
module tb_turf_buffer_scheduler;

    localparam int NBUF       = 4;
    localparam int HOLD_DELAY = 8;
    localparam int DEADTIME   = 16;
    localparam int LAT        = HOLD_DELAY + 1;

    logic            clk, rst_n;
    logic            rf_trig, soft_trig, pps1_trig, pps2_trig;
    logic            dis, clr_evt, clr_all, evid_reset, evt_ready, evt_valid;
    logic [11:0]     epoch;
    logic [NBUF-1:0] hold;
    logic [1:0]      evt_buf;
    logic [3:0]      evt_type;
    logic [31:0]     evt_id, next_id, status;

    int n_cmp = 0;
    int n_err = 0;
    logic [37:0] exp_q[$];

    typedef struct {
        logic [3:0]  trig;
        logic [1:0]  e_buf;
        logic [3:0]  e_type;
        logic [19:0] e_id;
        logic [3:0]  e_hold;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t vecs[4];

    turf_buffer_scheduler #(
        .NBUF(NBUF), .HOLD_DELAY(HOLD_DELAY), .DEADTIME(DEADTIME)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rf_trig_i    (rf_trig),
        .soft_trig_i  (soft_trig),
        .pps1_trig_i  (pps1_trig),
        .pps2_trig_i  (pps2_trig),
        .disable_i    (dis),
        .clr_evt_i    (clr_evt),
        .clr_all_i    (clr_all),
        .epoch_i      (epoch),
        .evid_reset_i (evid_reset),
        .hold_o       (hold),
        .evt_valid_o  (evt_valid),
        .evt_ready_i  (evt_ready),
        .evt_buf_o    (evt_buf),
        .evt_type_o   (evt_type),
        .evt_id_o     (evt_id),
        .next_id_o    (next_id),
        .buf_status_o (status)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_trig(input logic [3:0] m);
        rf_trig   = m[0];
        soft_trig = m[1];
        pps1_trig = m[2];
        pps2_trig = m[3];
    endtask

    task automatic pulse_trig(input logic [3:0] m);
        drive_trig(m);
        tick();
        drive_trig(4'b0000);
    endtask

    task automatic pulse_clr_evt();
        clr_evt = 1'b1;
        tick();
        clr_evt = 1'b0;
    endtask

    // Caller is one cycle past the grant cycle, so latency = ticks + 1.
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!evt_valid && n < 40) begin
            tick();
            n++;
        end
        chk(name, n + 1, LAT);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (status[14:13] != 2'd0 && n < 60) begin
            tick();
            n++;
        end
        chk(name, status[14:13], 2'd0);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            tick();
            if (evt_valid || status[12]) seen++;
        end
        chk(name, seen, 0);
    endtask

    task automatic run_event(input vec_t v, input string tag);
        exp_q.push_back({v.e_buf, v.e_type, epoch, v.e_id});
        pulse_trig(v.trig);
        tick();
        chk({tag, "_hold"}, hold, v.e_hold);
        chk({tag, "_occ"}, status[6:4], v.e_occ);
        chk({tag, "_lost"}, status[31:16], 0);
        chk({tag, "_evt"}, {evt_buf, evt_type, evt_id}, {v.e_buf, v.e_type, epoch, v.e_id});
        chk({tag, "_next_id"}, next_id, {epoch, v.e_id + 20'd1});
        wait_valid({tag, "_latency"});
        wait_idle({tag, "_idle"});
    endtask

    // scoreboard: every completed announce must match the oldest expectation
    always @(negedge clk) begin
        logic [37:0] e;
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL announce: got unexpected %0h expected none", {evt_buf, evt_type, evt_id});
            end else begin
                e = exp_q.pop_front();
                chk("announce", {evt_buf, evt_type, evt_id}, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive_trig(4'b0000);
        dis = 1'b0; clr_evt = 1'b0; clr_all = 1'b0; evid_reset = 1'b0;
        evt_ready = 1'b1;
        epoch = 12'h000;

        //          trig     buf   type     id     hold     occ
        vecs[0] = '{4'b0001, 2'd0, 4'b0001, 20'd0, 4'b0001, 3'd1};
        vecs[1] = '{4'b0101, 2'd1, 4'b0101, 20'd1, 4'b0011, 3'd2};
        vecs[2] = '{4'b1000, 2'd2, 4'b1000, 20'd2, 4'b0111, 3'd3};
        vecs[3] = '{4'b0010, 2'd3, 4'b0010, 20'd3, 4'b1111, 3'd4};

        repeat (3) @(posedge clk);
        #2;
        chk("rst_hold", hold, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_evt", {evt_buf, evt_type, evt_id}, 0);
        chk("rst_next_id", next_id, 0);
        chk("rst_status", status, 0);
        rst_n = 1'b1;
        epoch = 12'hABC;
        tick();
        chk("idle_next_id", next_id, 32'hABC0_0000);

        for (int i = 0; i < 4; i++) run_event(vecs[i], $sformatf("vec%0d", i));

        // ring full: fifth trigger waits, sixth is lost, one release regrants buf 0
        exp_q.push_back({2'd0, 4'b0001, 12'hABC, 20'd4});
        pulse_trig(4'b0001);
        repeat (5) tick();
        chk("full_stall_status", status, 32'h0000_804F);
        chk("full_stall_valid", evt_valid, 0);
        pulse_trig(4'b0001);
        chk("full_lost", status, 32'h0001_804F);
        pulse_clr_evt();
        chk("full_release", status, 32'h0001_043E);
        tick();
        chk("full_regrant", status, 32'h0001_B54F);
        chk("full_regrant_evt", {evt_buf, evt_type, evt_id}, {2'd1 - 2'd1, 4'b0001, 32'hABC0_0004});
        wait_valid("full_latency");
        wait_idle("full_idle");

        // ready held low: announce stays up with frozen fields
        pulse_clr_evt();
        chk("stall_release", status, 32'h0001_093D);
        evt_ready = 1'b0;
        exp_q.push_back({2'd1, 4'b0001, 12'hABC, 20'd5});
        pulse_trig(4'b0001);
        tick();
        wait_valid("stall_latency");
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("stall_stable_%0d", i), {evt_valid, evt_buf, evt_type, evt_id},
                {1'b1, 2'd1, 4'b0001, 32'hABC0_0005});
            tick();
        end
        evt_ready = 1'b1;
        tick();
        chk("stall_dead", {evt_valid, status[14:13]}, {1'b0, 2'd3});
        wait_idle("stall_idle");

        // clr_all during announce with two buffers held
        pulse_clr_evt();
        pulse_clr_evt();
        pulse_clr_evt();
        chk("clrall_setup", status, 32'h0001_0612);
        evt_ready = 1'b0;
        pulse_trig(4'b0001);
        tick();
        wait_valid("clrall_latency");
        chk("clrall_pre", {hold, evt_buf, evt_id[19:0], status[6:4]}, {4'b0110, 2'd2, 20'd6, 3'd2});
        pulse_trig(4'b0010);
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        chk("clrall_hold", hold, 0);
        chk("clrall_valid", evt_valid, 0);
        chk("clrall_status", status, 0);
        chk("clrall_next_id", next_id, 32'hABC0_0007);
        evt_ready = 1'b1;
        expect_quiet("clrall_no_pending", 30);

        // disabled pulses are dropped and not counted as lost
        dis = 1'b1;
        pulse_trig(4'b0001);
        pulse_trig(4'b0001);
        pulse_trig(4'b1111);
        dis = 1'b0;
        expect_quiet("disable_quiet", 20);
        chk("disable_status", status, 0);
        chk("disable_next_id", next_id, 32'hABC0_0007);

        // evid_reset coincident with a grant: that event takes ID 0
        epoch = 12'h123;
        exp_q.push_back({2'd0, 4'b1000, 12'h123, 20'd0});
        drive_trig(4'b1000);
        tick();
        drive_trig(4'b0000);
        evid_reset = 1'b1;
        tick();
        evid_reset = 1'b0;
        chk("evrst_evt_id", evt_id, 32'h1230_0000);
        chk("evrst_next_id", next_id, 32'h1230_0001);
        wait_valid("evrst_latency");
        wait_idle("evrst_idle");

        // counter wrap 0xFFFFF -> 0
        force dut.id_ctr = 20'hFFFFF;
        tick();
        release dut.id_ctr;
        chk("wrap_preset", next_id, 32'h123F_FFFF);
        exp_q.push_back({2'd1, 4'b0100, 12'h123, 20'hFFFFF});
        pulse_trig(4'b0100);
        tick();
        chk("wrap_evt_id", evt_id, 32'h123F_FFFF);
        chk("wrap_next_id", next_id, 32'h1230_0000);
        wait_valid("wrap_latency");
        wait_idle("wrap_idle");

        // asynchronous reset in the middle of a HOLD sequence
        pulse_trig(4'b0001);
        tick();
        tick();
        chk("arst_pre", {status[12], status[6:4], hold}, {1'b1, 3'd3, 4'b0111});
        #3 rst_n = 1'b0;
        #1;
        chk("arst_hold", hold, 0);
        chk("arst_valid", evt_valid, 0);
        chk("arst_evt", {evt_buf, evt_type, evt_id}, 0);
        chk("arst_status", status, 0);
        chk("arst_next_id", next_id, 32'h1230_0000);
        #2 rst_n = 1'b1;
        tick();
        chk("arst_after", status, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
